fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the 32-bit, word-addressed, 5-bit-opcode processor. It owns the program counter, drives the synchronous instruction memory and handles stall and branch/jump redirects. It presents one instruction per cycle, with its PC and PC+1, to the downstream control decoder in the decode stage.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/ifid_reg.sv | 32 +++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch and decode stages of the
// 32-bit, word-addressed, 5-bit-opcode processor.
//   NOP_INSTR     : encoding of add r0,r0,r0, used for pipeline bubbles
//   WORD_W        : datapath / instruction width
//   OPCODE_MSB/LSB: opcode field position inside an instruction word
//   opcode_e      : opcode constants shared with the control decoder
//   ifid_t        : contents of the IF/ID pipeline register
package cpu_pkg;

    localparam int          WORD_W     = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 27;

    typedef enum logic [4:0] {
        OP_ALU  = 5'b00000,
        OP_J    = 5'b00001,
        OP_BNE  = 5'b00010,
        OP_JAL  = 5'b00011,
        OP_JR   = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_BLT  = 5'b00110,
        OP_SW   = 5'b00111,
        OP_LW   = 5'b01000,
        OP_SETX = 5'b10101,
        OP_BEX  = 5'b10110
    } opcode_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc_plus1;
        logic              valid;
    } ifid_t;

    // Extract the opcode field of an instruction word.
    function automatic logic [4:0] opcode_of(input logic [WORD_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register (instr, pc, pc+1, valid).
//   clock  : rising-edge clock
//   reset  : synchronous active-high clear of all fields
//   enable : load d when high, hold when low
//   flush  : load a bubble (NOP, valid=0, pcs=0); wins over a low enable
//   d      : next contents from the fetch logic
//   q      : registered contents presented to decode
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q.instr    <= NOP_INSTR;
            q.pc       <= '0;
            q.pc_plus1 <= '0;
            q.valid    <= 1'b0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-memory address generation and
// IF/ID register for the word-addressed processor.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   stall          : hold PC and IF/ID
//   redirect       : taken branch/jump from a later stage; flushes IF/ID
//   redirect_pc    : target PC for redirect
//   imem_addr      : combinational read address (low bits of pc_next)
//   imem_data      : synchronous memory data for address held in pc
//   ifid_*         : instruction, its pc, pc+1 and valid flag to decode
//   instr_count    : saturating count of valid instructions loaded into IF/ID
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          PC_WIDTH = 12,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic [31:0]         ifid_instr,
    output logic [31:0]         ifid_pc,
    output logic [31:0]         ifid_pc_plus1,
    output logic                ifid_valid,
    output logic [31:0]         instr_count
);

    // pc is the address whose word is on imem_data this cycle.
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] pc_next;
    ifid_t       ifid_d;
    ifid_t       ifid_q;
    logic        load;

    assign pc_plus1 = pc + 32'd1;   // wraps 32'hFFFFFFFF -> 0

    always_comb begin
        pc_next = pc_plus1;
        if (reset)         pc_next = RESET_PC;
        else if (redirect) pc_next = redirect_pc;
        else if (stall)    pc_next = pc;   // re-read the same word
    end

    // Address comes from pc_next so the read data lines up with pc after the edge.
    assign imem_addr = pc_next[PC_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) pc <= RESET_PC;
        else       pc <= pc_next;
    end

    assign ifid_d.instr    = imem_data;
    assign ifid_d.pc       = pc;
    assign ifid_d.pc_plus1 = pc_plus1;
    assign ifid_d.valid    = 1'b1;

    ifid_reg u_ifid (
        .clock  (clock),
        .reset  (reset),
        .enable (!stall),
        .flush  (redirect),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc_plus1 = ifid_q.pc_plus1;
    assign ifid_valid    = ifid_q.valid;

    // A valid instruction enters IF/ID only on a plain (no stall/redirect) edge.
    assign load = !redirect && !stall;

    always_ff @(posedge clock) begin
        if (reset)
            instr_count <= '0;
        else if (load && (instr_count != 32'hFFFF_FFFF))
            instr_count <= instr_count + 32'd1;
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int          PW   = 12;
    localparam logic [31:0] RPC  = 32'h0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [PW-1:0] imem_addr;
    logic [31:0]   imem_data = '0;
    logic [31:0]   ifid_instr, ifid_pc, ifid_pc_plus1, instr_count;
    logic          ifid_valid;

    fetch_stage #(.PC_WIDTH(PW), .RESET_PC(RPC)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    // Memory word k holds 32'h1000_0000 + k; one-cycle synchronous read.
    function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
        return 32'h1000_0000 + {{(32-PW){1'b0}}, a};
    endfunction

    always @(posedge clock) imem_data <= mem_word(imem_addr);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc1;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the PC of the next instruction to enter decode, and
    // what decode currently holds.
    logic [31:0] m_fetch;
    exp_t        m_ifid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, check the address, advance model.
    task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc, input bit st);
        logic [31:0] exp_addr;
        @(negedge clock);
        reset = r; redirect = rd; redirect_pc = rpc; stall = st;
        #1;
        if (r)       exp_addr = RPC;
        else if (rd) exp_addr = rpc;
        else if (st) exp_addr = m_fetch;
        else         exp_addr = m_fetch + 1;
        check("imem_addr", {{(32-PW){1'b0}}, imem_addr}, {{(32-PW){1'b0}}, exp_addr[PW-1:0]});
        if (r) begin
            m_ifid  = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
            m_fetch = RPC;
        end else if (rd) begin
            m_ifid.instr = 32'h0; m_ifid.pc = 32'h0; m_ifid.pc1 = 32'h0; m_ifid.valid = 1'b0;
            m_fetch = rpc;
        end else if (!st) begin
            m_ifid.instr = mem_word(m_fetch[PW-1:0]);
            m_ifid.pc    = m_fetch;
            m_ifid.pc1   = m_fetch + 1;
            m_ifid.valid = 1'b1;
            if (m_ifid.count != 32'hFFFF_FFFF) m_ifid.count++;
            m_fetch = m_fetch + 1;
        end
        q.push_back(m_ifid);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Monitor: after each edge, compare DUT IF/ID against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ifid_instr", ifid_instr, e.instr);
                check("ifid_pc", ifid_pc, e.pc);
                check("ifid_pc_plus1", ifid_pc_plus1, e.pc1);
                check("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
                check("instr_count", instr_count, e.count);
            end
        end
    end

    initial begin
        int r;
        logic [31:0] t;
        m_fetch = RPC;
        m_ifid  = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        // reset then free run; decode sees pcs 0..5
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        run(6);
        // stall 3 cycles holding pc 5
        repeat (3) cycle(0, 0, 0, 1);
        run(2);                               // pcs 6, 7
        cycle(0, 1, 32'd40, 0);               // redirect to 40
        run(2);
        cycle(0, 1, 32'd100, 1);              // redirect + stall
        cycle(0, 0, 0, 1);                    // stall holds the bubble
        run(3);
        cycle(0, 1, 32'd15, 0);
        run(6);                               // reaches pc 20
        cycle(1, 0, 0, 0);                    // mid-stream reset
        run(3);
        cycle(0, 1, 32'hFFFF_FFFF, 0);        // wrap
        run(3);
        cycle(0, 1, 32'h0000_1005, 0);        // address truncation
        run(2);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            if (r < 2)       cycle(1, 0, 0, 0);
            else if (r < 12) cycle(0, 1, t, $urandom_range(0, 1) == 1);
            else if (r < 35) cycle(0, 0, 0, 1);
            else             cycle(0, 0, 0, 0);
        end
        @(posedge clock);
        #5;
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
